branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
// - Fetch-side producer of early-redirect signals for the PC register: predecodes the IF/ID instruction,
//   predicts B-type branches with a 2-bit saturating-counter BHT, always predicts JAL taken.
// - Drives jump_taken/PC_Jump (PC computes PC + PC_Jump - 4), tracks each prediction to MEM,
//   and raises mispredict/PC_savedMEM when a predicted-taken branch resolves not-taken.
// PARAMETERS
// - BHT_ENTRIES  64  counters in BHT; power of two, >= 2
// - IDX_LO       2   lowest PC bit used for BHT index; index = PC[IDX_LO +: log2(BHT_ENTRIES)]
// PORTS
// - clk               in   1   clock; all state updates on posedge
// - rst               in   1   synchronous, active-high reset
// - pipe_stall        in   1   hold all tracking records; no BHT update
// - flush             in   1   redirect (PC_select or CSR branch): clear ID- and EX-stage records
// - ID_valid          in   1   ID_instr/ID_PC hold a real instruction
// - ID_instr          in   32  instruction currently in IF/ID
// - ID_PC             in   32  address of ID_instr
// - MEM_branch_taken  in   1   actual outcome of the instruction now in MEM (valid only if it is B-type)
// - jump_taken        out  1   early redirect request for this cycle
// - PC_Jump           out  32  sign-extended B/J immediate of ID_instr; 0 when jump_taken=0
// - mispredict        out  1   MEM record is B-type, predicted taken, resolved not-taken
// - PC_savedMEM       out  32  PC of the MEM record (PC restarts at PC_savedMEM + 4)
// BEHAVIOUR
// - Prediction, combinational, zero latency (PC consumes it at the next edge):
//   JAL (opcode 1101111): jump_taken=1, PC_Jump=J-imm. B-type (1100011): jump_taken=counter[idx][1],
//   PC_Jump=B-imm. JALR and all others: jump_taken=0. Forced 0 when !ID_valid, flush, or rst.
// - Tracking records {valid, is_br, pred, pc[31:0], idx}: EX_rec <= ID values, MEM_rec <= EX_rec,
//   both on every edge with !pipe_stall. flush: EX_rec.valid <= 0 and ID capture suppressed;
//   MEM_rec still advances (it is older than the redirect).
// - mispredict = MEM_rec.valid & is_br & pred & !MEM_branch_taken; PC_savedMEM = MEM_rec.pc (0 when !valid).
//   Both outputs are pure functions of registered state plus MEM_branch_taken.
//   Predicted-not-taken but actually-taken is NOT a mispredict (normal ALU redirect covers it).
// - BHT update: posedge with MEM_rec.valid & is_br & !pipe_stall: counter[MEM_rec.idx] +1 if taken,
//   -1 if not; saturate at 2'b11 / 2'b00. JAL never touches the BHT.
// - Same-cycle read and update of one index: prediction uses the pre-update value.
// - Index arithmetic: bits above IDX_LO+log2(BHT_ENTRIES)-1 ignored (aliasing intended); PC_Jump two's complement.
// - Reset: all counters 2'b01 (weakly not-taken), both records invalid, pc fields 0;
//   outputs jump_taken=0, PC_Jump=0, mispredict=0, PC_savedMEM=0. Reset mid-flight discards all records.
// - rst dominates flush; flush dominates pipe_stall for EX_rec clearing.
// STRUCTURE
// - Shared package: opcode constants OP_BRANCH/OP_JAL/OP_JALR, bp_rec_t record struct,
//   counter encodings SNT/WNT/WT/ST.
// - One sub-module: bp_imm_decode (combinational B/J immediate extraction + is_br/is_jal flags).
// - BHT is a flop array (reset required; no RAM inference).
// TESTING
// - Reset, then ID_instr=BEQ +16 at 0x40 -> jump_taken=0, PC_Jump=0; record reaches MEM 2 cycles later.
// - JAL -8 at 0x100 -> same cycle jump_taken=1, PC_Jump=0xFFFFFFF8; BHT unchanged.
// - BEQ at 0x40 resolved taken twice -> counter 01->10->11; third fetch predicts jump_taken=1, PC_Jump=16.
// - Counter at 11, branch resolves not-taken in MEM -> mispredict=1, PC_savedMEM=0x40; counter 11->10.
// - flush with predicted-taken branch in EX -> 2 cycles later mispredict stays 0, BHT unchanged.
// - pipe_stall held 3 cycles with branch in MEM -> records, outputs and counters frozen; one update on release.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor.
// Holds the opcode constants the predecoder recognises, the 2-bit counter
// encodings, the tracking record carried from EX to MEM, and the counter
// saturation helper used by the BHT update path.
package branch_predictor_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Widest BHT index a record can carry; the predictor uses the low bits.
    localparam int IDX_MAX_W = 16;

    typedef struct packed {
        logic                 valid;
        logic                 is_br;
        logic                 pred;
        logic [31:0]          pc;
        logic [IDX_MAX_W-1:0] idx;
    } bp_rec_t;

    // Saturating step of a 2-bit counter towards the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Bundle between the pipeline and the branch predictor.
// master: pipeline side, drives stall/flush, the IF/ID instruction and the
//         MEM-stage branch outcome; receives the redirect and mispredict info.
// slave:  predictor side.
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic        pipe_stall;
    logic        flush;
    logic        ID_valid;
    logic [31:0] ID_instr;
    logic [31:0] ID_PC;
    logic        MEM_branch_taken;
    logic        jump_taken;
    logic [31:0] PC_Jump;
    logic        mispredict;
    logic [31:0] PC_savedMEM;

    modport master (
        output pipe_stall, flush, ID_valid, ID_instr, ID_PC, MEM_branch_taken,
        input  jump_taken, PC_Jump, mispredict, PC_savedMEM
    );

    modport slave (
        input  pipe_stall, flush, ID_valid, ID_instr, ID_PC, MEM_branch_taken,
        output jump_taken, PC_Jump, mispredict, PC_savedMEM
    );

endinterface

// File: rtl/branch_predictor_imm_decode.sv
// bp_imm_decode: combinational predecode of one RV32 instruction.
// Ports:
//   instr  in  32  instruction to inspect
//   is_br  out 1   B-type conditional branch
//   is_jal out 1   JAL
//   b_imm  out 32  sign-extended B-type offset
//   j_imm  out 32  sign-extended J-type offset
module bp_imm_decode
    import branch_predictor_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_br,
    output logic        is_jal,
    output logic [31:0] b_imm,
    output logic [31:0] j_imm
);

    // JALR targets depend on a register value, so it is never redirected early.
    always_comb begin
        is_br  = 1'b0;
        is_jal = 1'b0;
        case (instr[6:0])
            OP_BRANCH: is_br  = 1'b1;
            OP_JAL:    is_jal = 1'b1;
            OP_JALR:   is_jal = 1'b0;
            default:   is_br  = 1'b0;
        endcase
    end

    // Offsets are scattered across the encoding; bit 0 is always zero.
    assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: early-redirect source for the PC register.
// Predecodes the IF/ID instruction, predicts B-type branches from a BHT of
// 2-bit saturating counters, always predicts JAL taken, and follows every
// prediction to MEM so a predicted-taken branch that falls through can be
// recovered.
// Ports:
//   clk  in  clock, all state changes on posedge
//   rst  in  synchronous active-high reset
//   bus  slave modport of branch_predictor_if (stall/flush, IF/ID
//        instruction, MEM outcome in; jump_taken/PC_Jump,
//        mispredict/PC_savedMEM out)
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_LO      = 2
)
(
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];
    bp_rec_t          ex_rec_q, ex_rec_d;
    bp_rec_t          mem_rec_q, mem_rec_d;

    logic             id_is_br;
    logic             id_is_jal;
    logic [31:0]      id_b_imm;
    logic [31:0]      id_j_imm;
    logic [IDX_W-1:0] id_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             id_pred;
    logic             unused_idx_bits;

    bp_imm_decode u_dec (
        .instr  (bus.ID_instr),
        .is_br  (id_is_br),
        .is_jal (id_is_jal),
        .b_imm  (id_b_imm),
        .j_imm  (id_j_imm)
    );

    // Upper PC bits are dropped on purpose: distant branches share counters.
    assign id_idx  = bus.ID_PC[IDX_LO +: IDX_W];
    assign mem_idx = mem_rec_q.idx[IDX_W-1:0];
    assign id_pred = id_is_jal | (id_is_br & bht_q[id_idx][1]);

    assign unused_idx_bits = ^(mem_rec_q.idx >> IDX_W);

    // Zero-latency prediction; reads the counter before any same-edge update.
    always_comb begin
        bus.jump_taken = 1'b0;
        bus.PC_Jump    = 32'h0;
        if (bus.ID_valid && !bus.flush && !rst) begin
            if (id_is_jal) begin
                bus.jump_taken = 1'b1;
                bus.PC_Jump    = id_j_imm;
            end else if (id_is_br && bht_q[id_idx][1]) begin
                bus.jump_taken = 1'b1;
                bus.PC_Jump    = id_b_imm;
            end
        end
    end

    // MEM keeps advancing during a flush because its record predates the
    // redirect; only the younger EX record is squashed.
    always_comb begin
        ex_rec_d  = ex_rec_q;
        mem_rec_d = mem_rec_q;
        if (!bus.pipe_stall) begin
            mem_rec_d = ex_rec_q;
        end
        if (bus.flush) begin
            ex_rec_d = '0;
        end else if (!bus.pipe_stall) begin
            ex_rec_d.valid = bus.ID_valid;
            ex_rec_d.is_br = id_is_br;
            ex_rec_d.pred  = id_pred;
            ex_rec_d.pc    = bus.ID_PC;
            ex_rec_d.idx   = IDX_MAX_W'(id_idx);
        end
    end

    // Train only on resolved B-type branches; JAL never touches the table.
    always_comb begin
        bht_d = bht_q;
        if (mem_rec_q.valid && mem_rec_q.is_br && !bus.pipe_stall) begin
            bht_d[mem_idx] = ctr_next(bht_q[mem_idx], bus.MEM_branch_taken);
        end
    end

    // Only a taken prediction that fell through needs recovery here.
    assign bus.mispredict  = mem_rec_q.valid & mem_rec_q.is_br & mem_rec_q.pred
                             & ~bus.MEM_branch_taken;
    assign bus.PC_savedMEM = mem_rec_q.valid ? mem_rec_q.pc : 32'h0;

    // Counters start weakly not-taken; reset discards in-flight records.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= WNT;
            end
            ex_rec_q  <= '0;
            mem_rec_q <= '0;
        end else begin
            bht_q     <= bht_d;
            ex_rec_q  <= ex_rec_d;
            mem_rec_q <= mem_rec_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. A reference BHT and a queue of
// expected MEM-stage records are maintained alongside the DUT; each cycle the
// combinational prediction and the MEM-stage outputs are compared.
module tb_branch_predictor;

    localparam int K_OTHER = 0;
    localparam int K_BR    = 1;
    localparam int K_JAL   = 2;
    localparam int K_JALR  = 3;

    typedef struct {
        bit          valid;
        bit          isBr;
        bit          pred;
        logic [31:0] pc;
        int          idx;
    } tbRec;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    bit [1:0] bhtModel [64];
    tbRec     sbQ [$];

    always #5 clk = ~clk;

    branch_predictor_if bus ();

    branch_predictor #(.BHT_ENTRIES(64), .IDX_LO(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // BEQ x0,x0,imm
    function automatic logic [31:0] encBeq(input logic [31:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // JAL x0,imm
    function automatic logic [31:0] encJal(input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
    endfunction

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Put the reference model into its post-reset state.
    task automatic modelReset();
        tbRec empty;
        empty = '{valid: 1'b0, isBr: 1'b0, pred: 1'b0, pc: 32'h0, idx: 0};
        foreach (bhtModel[i]) bhtModel[i] = 2'b01;
        sbQ.delete();
        sbQ.push_back(empty);
        sbQ.push_back(empty);
    endtask

    // Drive one cycle, check outputs, then advance the model over the edge.
    task automatic applyStimulus(input bit v, input int kind, input logic [31:0] imm,
                                 input logic [31:0] pc, input bit fl, input bit st, input bit mt);
        logic [31:0] instr;
        int          idx;
        bit          ctrTaken;
        bit          expJt;
        logic [31:0] expPcj;
        tbRec        memRec;
        tbRec        newRec;
        tbRec        exRec;
        case (kind)
            K_BR:    instr = encBeq(imm);
            K_JAL:   instr = encJal(imm);
            K_JALR:  instr = 32'h00008067;
            default: instr = 32'h00500093;
        endcase
        @(negedge clk);
        rst                  = 1'b0;
        bus.ID_valid         = v;
        bus.ID_instr         = instr;
        bus.ID_PC            = pc;
        bus.flush            = fl;
        bus.pipe_stall       = st;
        bus.MEM_branch_taken = mt;
        #1;
        idx      = int'(pc[7:2]);
        ctrTaken = bhtModel[idx][1];
        expJt    = v && !fl && (kind == K_JAL || (kind == K_BR && ctrTaken));
        expPcj   = expJt ? imm : 32'h0;
        memRec   = sbQ[0];
        checkOutput("jump_taken", 32'(bus.jump_taken), 32'(expJt));
        checkOutput("PC_Jump", bus.PC_Jump, expPcj);
        checkOutput("mispredict", 32'(bus.mispredict),
                    32'(memRec.valid && memRec.isBr && memRec.pred && !mt));
        checkOutput("PC_savedMEM", bus.PC_savedMEM, memRec.valid ? memRec.pc : 32'h0);
        newRec = '{valid: v && !fl, isBr: kind == K_BR,
                   pred: (kind == K_JAL) || (kind == K_BR && ctrTaken), pc: pc, idx: idx};
        @(posedge clk);
        if (memRec.valid && memRec.isBr && !st) begin
            if (mt && bhtModel[memRec.idx] != 2'b11) bhtModel[memRec.idx] = bhtModel[memRec.idx] + 2'b01;
            if (!mt && bhtModel[memRec.idx] != 2'b00) bhtModel[memRec.idx] = bhtModel[memRec.idx] - 2'b01;
        end
        if (st) begin
            if (fl) begin
                exRec       = sbQ[1];
                exRec.valid = 1'b0;
                sbQ[1]      = exRec;
            end
        end else begin
            void'(sbQ.pop_front());
            sbQ.push_back(newRec);
        end
    endtask

    task automatic bubbles(input int n, input bit mt);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, K_OTHER, 32'h0, 32'h0, 1'b0, 1'b0, mt);
    endtask

    // Hold reset with a live JAL in IF/ID; the redirect must stay suppressed.
    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst          = 1'b1;
            bus.ID_valid = 1'b1;
            bus.ID_instr = encJal(32'hFFFFFFF8);
            bus.ID_PC    = 32'h100;
            #1;
            checkOutput("rst_jump_taken", 32'(bus.jump_taken), 32'h0);
            checkOutput("rst_PC_Jump", bus.PC_Jump, 32'h0);
            @(posedge clk);
        end
        modelReset();
    endtask

    initial begin
        logic [31:0] r;
        int          kind;
        logic [31:0] imm;
        rst                  = 1'b1;
        bus.pipe_stall       = 1'b0;
        bus.flush            = 1'b0;
        bus.ID_valid         = 1'b0;
        bus.ID_instr         = 32'h0;
        bus.ID_PC            = 32'h0;
        bus.MEM_branch_taken = 1'b0;
        modelReset();
        doReset(2);

        $display("[TB] BEQ +16 at 0x40, resolved taken");
        applyStimulus(1, K_BR, 32'd16, 32'h40, 0, 0, 0);
        bubbles(1, 0);
        bubbles(1, 1);

        $display("[TB] JAL -8 at 0x100, BHT untouched");
        applyStimulus(1, K_JAL, 32'hFFFFFFF8, 32'h100, 0, 0, 0);
        bubbles(2, 1);
        applyStimulus(1, K_BR, 32'd16, 32'h100, 0, 0, 0);
        bubbles(1, 0);
        bubbles(1, 0);

        $display("[TB] train to strongly taken, then fall through");
        applyStimulus(1, K_BR, 32'd16, 32'h40, 0, 0, 0);
        bubbles(1, 0);
        bubbles(1, 1);
        applyStimulus(1, K_BR, 32'd16, 32'h40, 0, 0, 0);
        bubbles(1, 0);
        bubbles(1, 0);

        $display("[TB] flush squashes predicted-taken branch in EX");
        applyStimulus(1, K_BR, 32'd16, 32'h40, 0, 0, 0);
        applyStimulus(1, K_JAL, 32'h20, 32'h44, 1, 0, 0);
        bubbles(1, 0);
        applyStimulus(1, K_BR, 32'd16, 32'h40, 0, 0, 0);
        bubbles(1, 0);
        bubbles(1, 0);

        $display("[TB] stall with branch in MEM");
        applyStimulus(1, K_BR, 32'd16, 32'h40, 0, 0, 0);
        bubbles(1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, K_OTHER, 32'h0, 32'h0, 0, 1, 1);
        bubbles(1, 1);
        applyStimulus(1, K_BR, 32'd16, 32'h40, 0, 0, 0);
        bubbles(1, 0);
        bubbles(1, 0);
        applyStimulus(1, K_BR, 32'd16, 32'h40, 0, 0, 0);
        bubbles(2, 0);

        $display("[TB] aliasing, JALR/ALU ops, back-to-back branches");
        applyStimulus(1, K_BR, 32'd8, 32'h140, 0, 0, 0);
        bubbles(1, 0);
        bubbles(1, 1);
        applyStimulus(1, K_BR, 32'd16, 32'h40, 0, 0, 0);
        applyStimulus(1, K_JALR, 32'h0, 32'h48, 0, 0, 0);
        applyStimulus(1, K_OTHER, 32'h0, 32'h4C, 0, 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(1, K_BR, 32'hFFFFFFFC, 32'h40, 0, 0, i[0]);
        bubbles(2, 0);

        $display("[TB] reset mid-flight");
        applyStimulus(1, K_BR, 32'd16, 32'h40, 0, 0, 1);
        applyStimulus(1, K_BR, 32'd16, 32'h40, 0, 0, 1);
        doReset(1);
        bubbles(2, 0);
        applyStimulus(1, K_BR, 32'd16, 32'h40, 0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 200; i++) begin
            r    = $urandom;
            kind = int'($urandom_range(0, 3));
            if (kind == K_JAL) imm = {{11{r[20]}}, r[20:1], 1'b0};
            else               imm = {{19{r[12]}}, r[12:1], 1'b0};
            applyStimulus(($urandom % 4) != 0, kind, imm,
                          {23'h0, 1'($urandom), 6'($urandom_range(0, 7)), 2'b00},
                          ($urandom % 8) == 0, ($urandom % 6) == 0, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
